// File: rtl/chess_clock_controller.sv
// chess_clock_controller: turn sequencer for a two-player chess clock.
// It drives the run enables and the shared clear of the white and black
// countdown timers, switches sides on move presses, supports pause/resume
// and latches the result when a timer runs out.
// Optional feature: define SWITCH_LOCKOUT_EN to ignore move presses for
// LOCKOUT_CYCLES cycles after each turn switch.
module chess_clock_controller #(
  parameter int unsigned LOCKOUT_CYCLES = 25_000_000,
  parameter int unsigned MOVE_W         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              move_white,
  input  logic              move_black,
  input  logic              pause,
  input  logic              timeout_white,
  input  logic              timeout_black,
  output logic              flag_white,
  output logic              flag_black,
  output logic              timer_clear,
  output logic              turn,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic [MOVE_W-1:0] move_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WHITE_RUN = 3'd1,
    S_BLACK_RUN = 3'd2,
    S_PAUSED    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   saved_turn_q, saved_turn_d;

  logic start_prev_q, white_prev_q, black_prev_q, pause_prev_q;
  logic start_ev_c, white_ev_c, black_ev_c, pause_ev_c;
  logic any_timeout_c, move_ok_c, switch_c;

  logic              flag_white_q, flag_white_d;
  logic              flag_black_q, flag_black_d;
  logic              timer_clear_q, timer_clear_d;
  logic              turn_q, turn_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        winner_q, winner_d;
  logic [MOVE_W-1:0] move_count_q, move_count_d;

  // One event per press: rising edge of each already-synchronized button.
  assign start_ev_c    = start & ~start_prev_q;
  assign white_ev_c    = move_white & ~white_prev_q;
  assign black_ev_c    = move_black & ~black_prev_q;
  assign pause_ev_c    = pause & ~pause_prev_q;
  assign any_timeout_c = timeout_white | timeout_black;

  // Previous-sample registers for the button edge detectors.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_prev_q <= 1'b0;
      white_prev_q <= 1'b0;
      black_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      start_prev_q <= start;
      white_prev_q <= move_white;
      black_prev_q <= move_black;
      pause_prev_q <= pause;
    end
  end

`ifdef SWITCH_LOCKOUT_EN
  localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  logic [LOCK_W-1:0] lock_q, lock_d;

  // Lockout down-counter: reloaded on every switch, free-running in pause, cleared in IDLE.
  always_comb begin
    lock_d = lock_q;
    if (state_d == S_IDLE) begin
      lock_d = '0;
    end else if (switch_c) begin
      lock_d = LOCK_W'(LOCKOUT_CYCLES);
    end else if (lock_q != '0) begin
      lock_d = lock_q - LOCK_W'(1);
    end
  end

  // Lockout counter register.
  always_ff @(posedge clock) begin
    if (reset) lock_q <= '0;
    else       lock_q <= lock_d;
  end

  assign move_ok_c = (lock_q == '0);
`else
  // No lockout: LOCKOUT_CYCLES has no effect in this build.
  if (LOCKOUT_CYCLES == 0) begin : g_lockout_unused
  end

  assign move_ok_c = 1'b1;
`endif

  // State register, including the side saved on pause.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      saved_turn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_turn_q <= saved_turn_d;
    end
  end

  // Next-state logic; priority within a cycle is timeout > move > pause.
  always_comb begin
    state_d      = state_q;
    saved_turn_d = saved_turn_q;
    case (state_q)
      S_IDLE: begin
        if (start_ev_c) state_d = S_WHITE_RUN;
      end
      S_WHITE_RUN: begin
        if (any_timeout_c) begin
          state_d = S_GAME_OVER;
        end else if (white_ev_c && move_ok_c) begin
          state_d = S_BLACK_RUN;
        end else if (pause_ev_c) begin
          state_d      = S_PAUSED;
          saved_turn_d = 1'b0;
        end
      end
      S_BLACK_RUN: begin
        if (any_timeout_c) begin
          state_d = S_GAME_OVER;
        end else if (black_ev_c && move_ok_c) begin
          state_d = S_WHITE_RUN;
        end else if (pause_ev_c) begin
          state_d      = S_PAUSED;
          saved_turn_d = 1'b1;
        end
      end
      S_PAUSED: begin
        if (any_timeout_c) begin
          state_d = S_GAME_OVER;
        end else if (pause_ev_c) begin
          state_d = saved_turn_q ? S_BLACK_RUN : S_WHITE_RUN;
        end
      end
      S_GAME_OVER: begin
        if (start_ev_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: outputs are computed from the upcoming state so they register on the same edge.
  always_comb begin
    switch_c      = ((state_q == S_WHITE_RUN) && (state_d == S_BLACK_RUN)) ||
                    ((state_q == S_BLACK_RUN) && (state_d == S_WHITE_RUN));
    flag_white_d  = (state_d == S_WHITE_RUN);
    flag_black_d  = (state_d == S_BLACK_RUN);
    timer_clear_d = (state_d == S_IDLE);
    game_over_d   = (state_d == S_GAME_OVER);
    turn_d        = turn_q;
    winner_d      = winner_q;
    move_count_d  = move_count_q;
    case (state_d)
      S_IDLE: begin
        turn_d       = 1'b0;
        winner_d     = 2'b00;
        move_count_d = '0;
      end
      S_WHITE_RUN: turn_d = 1'b0;
      S_BLACK_RUN: turn_d = 1'b1;
      S_GAME_OVER: begin
        // Result bits line up as {white flagged, black flagged}: 10, 01 or 11 (draw).
        if (state_q != S_GAME_OVER) winner_d = {timeout_white, timeout_black};
      end
      default: ;
    endcase
    if (switch_c && (move_count_q != '1)) move_count_d = move_count_q + MOVE_W'(1);
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      flag_white_q  <= 1'b0;
      flag_black_q  <= 1'b0;
      timer_clear_q <= 1'b1;
      turn_q        <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
      move_count_q  <= '0;
    end else begin
      flag_white_q  <= flag_white_d;
      flag_black_q  <= flag_black_d;
      timer_clear_q <= timer_clear_d;
      turn_q        <= turn_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      move_count_q  <= move_count_d;
    end
  end

  assign flag_white  = flag_white_q;
  assign flag_black  = flag_black_q;
  assign timer_clear = timer_clear_q;
  assign turn        = turn_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign move_count  = move_count_q;

endmodule

// File: tb/tb_chess_clock_controller.sv
// Directed bench for chess_clock_controller (LOCKOUT_CYCLES=4, MOVE_W=3).
// Status word layout: {flag_white, flag_black, timer_clear, turn, game_over, winner[1:0], move_count[2:0]}.
module tb_chess_clock_controller;

  logic       clock;
  logic       reset;
  logic       start, move_white, move_black, pause;
  logic       timeout_white, timeout_black;
  logic       flag_white, flag_black, timer_clear, turn, game_over;
  logic [1:0] winner;
  logic [2:0] move_count;

  logic [9:0] obs;
  logic [9:0] exp_v;
  int         vectors;
  int         failures;

  chess_clock_controller #(
    .LOCKOUT_CYCLES(4),
    .MOVE_W        (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .move_white   (move_white),
    .move_black   (move_black),
    .pause        (pause),
    .timeout_white(timeout_white),
    .timeout_black(timeout_black),
    .flag_white   (flag_white),
    .flag_black   (flag_black),
    .timer_clear  (timer_clear),
    .turn         (turn),
    .game_over    (game_over),
    .winner       (winner),
    .move_count   (move_count)
  );

  assign obs = {flag_white, flag_black, timer_clear, turn, game_over, winner, move_count};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The two run enables must never be high together.
  always @(negedge clock) begin
    if (!reset) begin
      vectors++;
      if (flag_white && flag_black) begin
        failures++;
        $display("FAIL both_flags_high got fw=%b fb=%b want not both 1", flag_white, flag_black);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    start = 0; move_white = 0; move_black = 0; pause = 0;
    timeout_white = 0; timeout_black = 0;
    reset = 1;
    idle(2);
    reset = 0;
    vectors++; exp_v = {5'b00100, 2'b00, 3'd0};
    if (obs !== exp_v) begin failures++; $display("FAIL reset_values got %b want %b", obs, exp_v); end
  endtask

  task automatic test_start();
    start = 1; tick(); start = 0;
    vectors++; exp_v = {5'b10000, 2'b00, 3'd0};
    if (obs !== exp_v) begin failures++; $display("FAIL start_to_run got %b want %b", obs, exp_v); end
    idle(1);
  endtask

  task automatic test_held_move();
    move_white = 1; move_black = 1;
    tick();
    vectors++; exp_v = {5'b01010, 2'b00, 3'd1};
    if (obs !== exp_v) begin failures++; $display("FAIL held_move_first got %b want %b", obs, exp_v); end
    idle(9);
    vectors++;
    if (obs !== exp_v) begin failures++; $display("FAIL held_move_10cyc got %b want %b", obs, exp_v); end
    move_white = 0; move_black = 0;
    idle(1);
  endtask

  task automatic test_pause();
    pause = 1; tick();
    vectors++; exp_v = {5'b00010, 2'b00, 3'd1};
    if (obs !== exp_v) begin failures++; $display("FAIL pause_enter got %b want %b", obs, exp_v); end
    idle(2); pause = 0; idle(1);
    vectors++;
    if (obs !== exp_v) begin failures++; $display("FAIL pause_held got %b want %b", obs, exp_v); end
    move_black = 1; tick(); move_black = 0;
    vectors++;
    if (obs !== exp_v) begin failures++; $display("FAIL move_in_pause got %b want %b", obs, exp_v); end
    idle(1);
    pause = 1; tick(); pause = 0;
    vectors++; exp_v = {5'b01010, 2'b00, 3'd1};
    if (obs !== exp_v) begin failures++; $display("FAIL pause_resume got %b want %b", obs, exp_v); end
    idle(5);
  endtask

  task automatic test_timeout();
    move_black = 1; tick(); move_black = 0;
    vectors++; exp_v = {5'b10000, 2'b00, 3'd2};
    if (obs !== exp_v) begin failures++; $display("FAIL black_move got %b want %b", obs, exp_v); end
    idle(5);
    timeout_white = 1; move_white = 1; tick();
    vectors++; exp_v = {5'b00001, 2'b10, 3'd2};
    if (obs !== exp_v) begin failures++; $display("FAIL timeout_over_move got %b want %b", obs, exp_v); end
    idle(2); timeout_white = 0; move_white = 0; idle(1);
    vectors++;
    if (obs !== exp_v) begin failures++; $display("FAIL game_over_frozen got %b want %b", obs, exp_v); end
    start = 1; tick(); start = 0;
    vectors++; exp_v = {5'b00100, 2'b00, 3'd0};
    if (obs !== exp_v) begin failures++; $display("FAIL over_to_idle got %b want %b", obs, exp_v); end
    idle(1);
    start = 1; tick(); start = 0; idle(1);
    move_white = 1; tick(); move_white = 0; idle(1);
    pause = 1; tick(); pause = 0; idle(1);
    vectors++; exp_v = {5'b00010, 2'b00, 3'd1};
    if (obs !== exp_v) begin failures++; $display("FAIL pause_before_draw got %b want %b", obs, exp_v); end
    timeout_white = 1; timeout_black = 1; tick();
    vectors++; exp_v = {5'b00011, 2'b11, 3'd1};
    if (obs !== exp_v) begin failures++; $display("FAIL draw_in_pause got %b want %b", obs, exp_v); end
    timeout_white = 0; timeout_black = 0; idle(1);
    move_white = 1; pause = 1; tick(); move_white = 0; pause = 0;
    vectors++;
    if (obs !== exp_v) begin failures++; $display("FAIL inputs_in_over got %b want %b", obs, exp_v); end
    idle(1);
    start = 1; tick(); start = 0;
    vectors++; exp_v = {5'b00100, 2'b00, 3'd0};
    if (obs !== exp_v) begin failures++; $display("FAIL draw_to_idle got %b want %b", obs, exp_v); end
    idle(1);
    start = 1; tick(); start = 0; idle(1);
    timeout_black = 1; tick();
    vectors++; exp_v = {5'b00001, 2'b01, 3'd0};
    if (obs !== exp_v) begin failures++; $display("FAIL white_wins got %b want %b", obs, exp_v); end
    timeout_black = 0; idle(1);
    start = 1; tick(); start = 0; idle(1);
  endtask

  task automatic test_saturate();
    int cnt;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 10; i++) begin
      idle(5);
      if (i % 2 == 0) begin move_white = 1; tick(); move_white = 0; end
      else            begin move_black = 1; tick(); move_black = 0; end
      cnt = (i + 1 > 7) ? 7 : i + 1;
      vectors++;
      exp_v = (i % 2 == 0) ? {5'b01010, 2'b00, 3'(cnt)} : {5'b10000, 2'b00, 3'(cnt)};
      if (obs !== exp_v) begin failures++; $display("FAIL saturate_%0d got %b want %b", i, obs, exp_v); end
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    reset = 1; tick(); reset = 0;
    start = 1; tick(); start = 0; idle(1);
    move_white = 1; tick(); move_white = 0;
    vectors++; exp_v = {5'b01010, 2'b00, 3'd1};
    if (obs !== exp_v) begin failures++; $display("FAIL switch_to_black got %b want %b", obs, exp_v); end
`ifdef SWITCH_LOCKOUT_EN
    tick();
    move_black = 1; tick(); move_black = 0;
    vectors++;
    if (obs !== exp_v) begin failures++; $display("FAIL lockout_reject got %b want %b", obs, exp_v); end
    idle(2);
    move_black = 1; tick(); move_black = 0;
    vectors++; exp_v = {5'b10000, 2'b00, 3'd2};
    if (obs !== exp_v) begin failures++; $display("FAIL lockout_accept got %b want %b", obs, exp_v); end
`else
    move_black = 1; tick(); move_black = 0;
    vectors++; exp_v = {5'b10000, 2'b00, 3'd2};
    if (obs !== exp_v) begin failures++; $display("FAIL immediate_accept got %b want %b", obs, exp_v); end
`endif
    idle(5);
  endtask

  task automatic test_reset_mid();
    move_white = 1; tick(); move_white = 0;
    vectors++; exp_v = {5'b01010, 2'b00, 3'd3};
    if (obs !== exp_v) begin failures++; $display("FAIL pre_reset_move got %b want %b", obs, exp_v); end
    reset = 1; tick();
    vectors++; exp_v = {5'b00100, 2'b00, 3'd0};
    if (obs !== exp_v) begin failures++; $display("FAIL reset_mid_game got %b want %b", obs, exp_v); end
    reset = 0; tick();
    vectors++;
    if (obs !== exp_v) begin failures++; $display("FAIL idle_after_reset got %b want %b", obs, exp_v); end
  endtask

  initial begin
    vectors  = 0;
    failures = 0;
    test_reset();
    test_start();
    test_held_move();
    test_pause();
    test_timeout();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
